lcd_hd44780_ctrl: RTL
=====================

Name: lcd_hd44780_ctrl

Overview:
- Peripheral-side consumer of the LSU's memory-mapped LCD output.
- Takes byte-wide write requests (command or character) over a valid/ready handshake.
- Drives the 8-bit HD44780-compatible character-LCD bus with correct setup, enable-pulse, hold and execution timing.
- Runs the mandatory power-up init sequence by itself before accepting any request.

Parameters:
T_PWRUP_CYC, 750000, power-up wait before first init command (15 ms @ 50 MHz)
T_SETUP_CYC, 2, RS/DATA valid before EN rises
T_EN_CYC, 12, EN high width
T_HOLD_CYC, 2, RS/DATA held after EN falls
T_EXEC_CYC, 2000, execution wait for normal commands/characters (40 us)
T_LONG_CYC, 82000, execution wait for clear/home (1.64 ms)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  controller can accept a request
req_rs_i  in  1  0 = command, 1 = character data
req_data_i  in  8  command/character byte
lcd_on_i  in  1  backlight/power request from the LSU LCD register
init_done_o  out  1  init sequence complete (sticky until reset)
busy_o  out  1  high whenever not idle-and-ready
lcd_data_o  out  8  LCD DB[7:0]
lcd_rs_o  out  1  LCD RS
lcd_rw_o  out  1  LCD RW; always 0, write-only
lcd_en_o  out  1  LCD E strobe
lcd_on_o  out  1  registered copy of lcd_on_i

Behaviour:
- Reset (async, active-low) values:
  - lcd_data_o = 0, lcd_rs_o = 0, lcd_rw_o = 0, lcd_en_o = 0, lcd_on_o = 0.
  - req_ready_o = 0, init_done_o = 0, busy_o = 1.
  - FSM = PWRUP, init index = 0.
- Reset mid-transfer: EN drops to 0 immediately (asynchronously). The full init sequence reruns after release.
- All outputs are registered. Each timed state lasts exactly its parameter's number of clock cycles, counted by a single down-counter reloaded on state entry. The counter is wide enough for max(T_PWRUP_CYC, T_LONG_CYC).
- States:
  - PWRUP: wait T_PWRUP_CYC, then go to LOAD.
  - LOAD (1 cycle): drive init byte[index] with RS = 0.
    - Init bytes in order: 0x38 function set, 0x0C display on, 0x01 clear, 0x06 entry mode.
    - Go to SETUP.
  - SETUP: EN = 0, DATA/RS stable, T_SETUP_CYC cycles.
  - ENH: EN = 1, T_EN_CYC cycles.
  - HOLD: EN = 0, DATA/RS unchanged, T_HOLD_CYC cycles.
  - WAIT: T_LONG_CYC if the byte is long, else T_EXEC_CYC. Then:
    - During init with index < 3: increment index, go to LOAD.
    - During init with index == 3: set init_done_o, go to IDLE.
    - Otherwise: go to IDLE.
  - IDLE: req_ready_o = 1, busy_o = 0.
    - On an edge with req_valid_i = 1, the request is accepted.
    - On that same edge, req_data_i/req_rs_i are latched onto lcd_data_o/lcd_rs_o, ready drops, and the FSM goes to SETUP.
- Long command: RS = 0 and data[7:2] = 0 and data[1:0] != 0 (0x01, 0x02, 0x03).
- RS = 1 is never long, whatever the data value.
- Accept-to-ready latency: T_SETUP_CYC + T_EN_CYC + T_HOLD_CYC + wait, in cycles.
- Back-to-back requests:
  - A request held valid while the controller is busy is not sampled.
  - It is accepted on the first IDLE edge, i.e. the cycle ready is high.
- Requests arriving before init_done_o are held off (ready = 0). They are never dropped, provided the requester holds valid.
- lcd_data_o/lcd_rs_o keep the last transferred value while IDLE.
- lcd_rw_o is constant 0.
- lcd_on_o follows lcd_on_i with 1-cycle latency, independent of the FSM and of init state.

Test Plan:
Bench parameters: T_PWRUP=20, T_SETUP=1, T_EN=3, T_HOLD=1, T_EXEC=5, T_LONG=10.
1. Reset release, no requests:
   - Bus carries 0x38, 0x0C, 0x01, 0x06 with RS = 0, each with one 3-cycle EN pulse.
   - init_done_o and req_ready_o rise exactly 20 + 4 LOAD + (10 + 10 + 15 + 10) = 69 cycles after release.
   - req_ready_o stays 0 throughout.
2. After init, request RS=1 data 0x41:
   - On the accept edge, lcd_data_o = 0x41 and lcd_rs_o = 1.
   - EN is high for cycles 2–4 after accept.
   - req_ready_o returns 10 cycles after accept.
3. Requests RS=0 0x01 and RS=0 0x02:
   - Each gives a 15-cycle accept-to-ready latency.
   - A request RS=1 0x01 gives 10 cycles.
4. req_valid_i held high for 3 consecutive requests:
   - Exactly 3 acceptances, spaced 11 cycles apart (10 busy + 1 IDLE).
   - No EN pulse overlap; DATA stable throughout each SETUP–HOLD window.
5. Assert rst_ni during ENH of a user request:
   - lcd_en_o falls immediately; init_done_o = 0; ready = 0.
   - After release, the full init sequence repeats with the case-1 timing.
6. Toggle lcd_on_i 0→1→0 during PWRUP and during a transfer:
   - lcd_on_o mirrors it 1 cycle later.
   - No effect on FSM timing.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_ctrl
//
// Drives an 8-bit HD44780-compatible character LCD from byte-wide write
// requests. After reset it waits out the LCD power-up time and issues the
// init sequence (function set, display on, clear, entry mode) on its own.
// Only then does it accept requests over a valid/ready handshake. Every
// byte goes through the same timed sequence: address/data setup, the EN
// pulse, hold, and then the execution wait.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake; accepted on an edge with both high
//   req_rs_i                 0 = command byte, 1 = character byte
//   req_data_i[7:0]          command/character byte
//   lcd_on_i / lcd_on_o      backlight/power request, registered pass-through
//   init_done_o              init sequence finished (sticky until reset)
//   busy_o                   high whenever not idle-and-ready
//   lcd_data_o[7:0]          LCD DB[7:0]
//   lcd_rs_o                 LCD RS
//   lcd_rw_o                 LCD RW, tied to write
//   lcd_en_o                 LCD E strobe
// ---------------------------------------------------------------------------
module lcd_hd44780_ctrl #(
    parameter int unsigned T_PWRUP_CYC = 750000,
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 12,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_LONG_CYC  = 82000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    input  logic       lcd_on_i,
    output logic       init_done_o,
    output logic       busy_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic       lcd_on_o
);

    localparam int unsigned T_MAX = (T_PWRUP_CYC > T_LONG_CYC) ? T_PWRUP_CYC : T_LONG_CYC;
    localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

    // Reload values: a state lasting N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] CNT_PWRUP = CNT_W'(T_PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_EXEC  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(T_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_SETUP,
        ST_ENH,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             on_q, on_d;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    // Character writes are never long.
    function automatic logic is_long(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;  // function set: 8-bit, 2 lines, 5x8
            2'd1:    b = 8'h0C;  // display on, cursor off
            2'd2:    b = 8'h01;  // clear display
            default: b = 8'h06;  // entry mode: increment, no shift
        endcase
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        data_d  = data_q;
        rs_d    = rs_q;
        on_d    = lcd_on_i;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOAD;
                    data_d  = init_byte(idx_q);
                    rs_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LOAD: begin
                state_d = ST_SETUP;
                cnt_d   = CNT_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ENH;
                    cnt_d   = CNT_EN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ENH: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_long(rs_q, data_q) ? CNT_LONG : CNT_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_LOAD;
                        data_d  = init_byte(idx_q + 2'd1);
                        rs_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_IDLE: begin
                // Latching on the accept edge puts the byte on the bus at once,
                // so SETUP timing starts on the very next cycle.
                if (req_valid_i) begin
                    data_d  = req_data_i;
                    rs_d    = req_rs_i;
                    state_d = ST_SETUP;
                    cnt_d   = CNT_SETUP;
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = CNT_PWRUP;
            end
        endcase

        // Strobes are decoded from the next state so they are registered and
        // line up exactly with the state they belong to.
        en_d    = (state_d == ST_ENH);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_PWRUP;
            cnt_q   <= CNT_PWRUP;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            on_q    <= on_d;
        end
    end

    assign req_ready_o = ready_q;
    assign init_done_o = done_q;
    assign busy_o      = busy_q;
    assign lcd_data_o  = data_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = en_q;
    assign lcd_on_o    = on_q;

endmodule
